vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   640x480@60 VGA timing generator driven by the 25 MHz pixel clock from the clock divider.
//   Produces HSYNC/VSYNC, the visible-area flag, pixel coordinates and line/frame strobes
//   for the downstream Morse display/renderer. All outputs are registered and glitch-free.
// PARAMETERS
//   H_VISIBLE 640  visible pixels per line
//   H_FRONT   16   horizontal front porch (pixels)
//   H_SYNC    96   horizontal sync width (pixels)
//   H_BACK    48   horizontal back porch (pixels)
//   V_VISIBLE 480  visible lines per frame
//   V_FRONT   10   vertical front porch (lines)
//   V_SYNC    2    vertical sync width (lines)
//   V_BACK    33   vertical back porch (lines)
//   SYNC_POL  0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk         in   1   25 MHz pixel clock (divider output); all logic on posedge
//   reset       in   1   asynchronous, active-low (0 = reset)
//   enable      in   1   advance timing by one pixel on this edge when 1
//   hsync       out  1   horizontal sync, level per SYNC_POL
//   vsync       out  1   vertical sync, level per SYNC_POL
//   video_on    out  1   1 while current pixel is inside visible area
//   pixel_x     out  10  current horizontal count, 0..H_TOTAL-1
//   pixel_y     out  10  current vertical count, 0..V_TOTAL-1
//   line_tick   out  1   1-cycle strobe on entry to pixel_x==0
//   frame_tick  out  1   1-cycle strobe on entry to (0,0)
//   frame_count out  8   frames started since reset, mod 256
// BEHAVIOUR
//   - H_TOTAL = sum of H_* params (800); V_TOTAL = sum of V_* params (525).
//   - Reset (reset==0, async, immediate): h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1,
//     hsync=vsync=~SYNC_POL, video_on=0, line_tick=0, frame_tick=0,
//     pixel_x=pixel_y=0, frame_count=8'hFF. Reset mid-frame aborts the frame; no partial strobes.
//   - Each posedge with enable=1: h_cnt wraps H_TOTAL-1 -> 0, else +1; on h wrap, v_cnt wraps
//     V_TOTAL-1 -> 0, else +1. First enabled edge after reset therefore lands on (0,0).
//   - Outputs are registered from next-state counters: after every edge pixel_x==h_cnt,
//     pixel_y==v_cnt (zero latency between counters and decoded outputs).
//   - hsync = SYNC_POL iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//   - vsync = SYNC_POL iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
//   - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
//   - line_tick=1 for exactly the cycle after an enabled edge that made h_cnt 0.
//   - frame_tick=1 for exactly the cycle after an enabled edge that made (h,v)=(0,0);
//     frame_count increments (wraps 255->0) on that same edge, so first frame reads 0.
//   - enable=0: counters, hsync, vsync, video_on, pixel_x/y, frame_count hold;
//     line_tick and frame_tick forced 0 (never stretched across stalled cycles).
//   - Counter arithmetic in 10 bits; no out-of-range values ever reachable.
// TESTING
//   1. reset=0 3 cycles, release, enable=1 -> 1st edge: x=0,y=0,video_on=1,line_tick=1,
//      frame_tick=1,frame_count=0,hsync=vsync=1; 2nd edge: ticks=0, x=1.
//   2. Run 1 line -> video_on falls at x=640; hsync=0 exactly for x=656..751 (96 cycles);
//      line_tick period 800 cycles, always 1 cycle wide.
//   3. Run 1 full frame -> vsync=0 exactly for y=490..491 (1600 cycles); frame_tick period
//      420000 cycles; frame_count 0->1; video_on=0 for all y>=480.
//   4. At x=100 drive enable=0 for 5 cycles -> all outputs frozen, ticks 0; resume -> x=101.
//   5. Assert reset between edges at (300,200) -> outputs go to reset values without a clock;
//      release -> next enabled edge gives (0,0), frame_count=0.
//   6. Small params (H 8/1/2/1, V 4/1/1/1) run 256 frames -> frame_count wraps 255->0,
//      sync widths 2 px / 1 line, strobe counts match.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters with registered sync,
// blanking, coordinate and strobe outputs, advanced one pixel per enabled clock.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Reset parks the counters on the last pixel so the first enabled edge lands on (0,0).
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       hs_act;
    logic       vs_act;
    logic       vis_nxt;
    logic       line_start;
    logic       frame_start;

    // NOTE: every signal assigned in this block gets a value on all paths, so no latch is inferred.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Output decode works on the next-state counters so the registered outputs
    // line up with the counters on the same edge.
    always_comb begin
        hs_act      = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_act      = (v_nxt >= VS_START) && (v_nxt < VS_END);
        vis_nxt     = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        line_start  = (h_nxt == 10'd0);
        frame_start = line_start && (v_nxt == 10'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= 8'hFF;
        end else if (enable) begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            hsync      <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync      <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on   <= vis_nxt;
            pixel_x    <= h_nxt;
            pixel_y    <= v_nxt;
            line_tick  <= line_start;
            frame_tick <= frame_start;
            if (frame_start) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            // Stalled: everything holds except the strobes, which must not stretch.
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full 640x480 timing on line scale, plus a
// tiny-parameter instance run through 256 frames for vertical and wrap behaviour.
module tb_vga_sync_gen;

    logic clk;
    logic rst_big, en_big, rst_small, en_small;

    logic       b_hs, b_vs, b_vid, b_lt, b_ft;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;

    logic       s_hs, s_vs, s_vid, s_lt, s_ft;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    int n_cmp = 0;
    int n_bad = 0;

    vga_sync_gen u_big (
        .clk(clk), .reset(rst_big), .enable(en_big),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
        .pixel_x(b_x), .pixel_y(b_y),
        .line_tick(b_lt), .frame_tick(b_ft), .frame_count(b_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .reset(rst_small), .enable(en_small),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
        .pixel_x(s_x), .pixel_y(s_y),
        .line_tick(s_lt), .frame_tick(s_ft), .frame_count(s_fc)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_x, exp_y;
    int errs, hs_low, vs_low, vid_cnt, lt_cnt, ft_cnt, lt_pos;
    logic [7:0] fc_before_wrap;

    initial begin
        rst_big = 1'b0; en_big = 1'b0;
        rst_small = 1'b0; en_small = 1'b0;

        // ---- Reset state ----
        repeat (3) step();
        check("rst_x", b_x, 0);
        check("rst_y", b_y, 0);
        check("rst_hs", b_hs, 1);
        check("rst_vs", b_vs, 1);
        check("rst_vid", b_vid, 0);
        check("rst_ticks", {b_lt, b_ft}, 0);
        check("rst_fc", b_fc, 8'hFF);

        // ---- First enabled edges ----
        rst_big = 1'b1; en_big = 1'b1;
        step();
        check("e1_xy", {b_x, b_y}, 0);
        check("e1_vid", b_vid, 1);
        check("e1_lt", b_lt, 1);
        check("e1_ft", b_ft, 1);
        check("e1_fc", b_fc, 0);
        check("e1_sync", {b_hs, b_vs}, 2'b11);
        step();
        check("e2_ticks", {b_lt, b_ft}, 0);
        check("e2_x", b_x, 1);

        // ---- Rest of line 0 up to (0,1) ----
        errs = 0; hs_low = 0; vid_cnt = 0; lt_cnt = 0; lt_pos = -1;
        for (int s = 2; s <= 800; s++) begin
            step();
            exp_x = s % 800;
            exp_y = (s == 800) ? 1 : 0;
            if (b_x !== 10'(exp_x) || b_y !== 10'(exp_y)) errs++;
            if (b_vid !== (exp_x < 640)) errs++;
            if (b_hs !== !(exp_x >= 656 && exp_x < 752)) errs++;
            if (b_vs !== 1'b1 || b_ft !== 1'b0) errs++;
            if (!b_hs) hs_low++;
            if (b_vid) vid_cnt++;
            if (b_lt) begin
                lt_cnt++;
                lt_pos = s;
            end
        end
        check("line_errs", errs, 0);
        check("hs_low_cnt", hs_low, 96);
        check("vid_cnt", vid_cnt, 639);
        check("lt_cnt", lt_cnt, 1);
        check("lt_period", lt_pos, 800);
        check("line1_lt", b_lt, 1);

        // ---- Stall right after a line tick: strobe must drop, position holds ----
        en_big = 1'b0;
        step();
        check("stall_lt", b_lt, 0);
        check("stall_xy", {b_x, b_y}, {10'd0, 10'd1});
        en_big = 1'b1;
        repeat (100) step();
        check("at_x100", {b_x, b_y}, {10'd100, 10'd1});

        // ---- Five-cycle stall at x=100 ----
        en_big = 1'b0;
        errs = 0;
        repeat (5) begin
            step();
            if (b_x !== 10'd100 || b_y !== 10'd1) errs++;
            if (b_vid !== 1'b1 || b_hs !== 1'b1 || b_vs !== 1'b1) errs++;
            if (b_lt !== 1'b0 || b_ft !== 1'b0 || b_fc !== 8'd0) errs++;
        end
        check("freeze_errs", errs, 0);
        en_big = 1'b1;
        step();
        check("resume_x", b_x, 101);

        // ---- Async reset between edges ----
        repeat (199) step();
        check("at_x300", {b_x, b_y}, {10'd300, 10'd1});
        #5;
        rst_big = 1'b0;
        #1;
        check("arst_xy", {b_x, b_y}, 0);
        check("arst_vid", b_vid, 0);
        check("arst_fc", b_fc, 8'hFF);
        check("arst_sync", {b_hs, b_vs}, 2'b11);
        step();
        rst_big = 1'b1;
        step();
        check("rel_xy", {b_x, b_y}, 0);
        check("rel_fc", b_fc, 0);
        check("rel_ft", b_ft, 1);
        en_big = 1'b0;

        // ---- Small instance: 256 frames (12 x 7 = 84 pixels each) ----
        rst_small = 1'b1; en_small = 1'b1;
        step();
        check("sm_e1", {s_x, s_y, s_fc}, {10'd0, 10'd0, 8'd0});
        check("sm_e1_ticks", {s_lt, s_ft}, 2'b11);
        check("sm_e1_vid", s_vid, 1);
        exp_x = 0; exp_y = 0;
        errs = 0; hs_low = 0; vs_low = 0; lt_cnt = 0; ft_cnt = 0;
        fc_before_wrap = 8'h00;
        for (int s = 1; s <= 256 * 84; s++) begin
            step();
            exp_x = (exp_x == 11) ? 0 : exp_x + 1;
            if (exp_x == 0) exp_y = (exp_y == 6) ? 0 : exp_y + 1;
            if (s_x !== 10'(exp_x) || s_y !== 10'(exp_y)) errs++;
            if (s_vid !== (exp_x < 8 && exp_y < 4)) errs++;
            if (s_hs !== !(exp_x == 9 || exp_x == 10)) errs++;
            if (s_vs !== (exp_y != 5)) errs++;
            if (s_lt !== (exp_x == 0)) errs++;
            if (s_ft !== (exp_x == 0 && exp_y == 0)) errs++;
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_lt) lt_cnt++;
            if (s_ft) ft_cnt++;
            if (s == 255 * 84) fc_before_wrap = s_fc;
        end
        check("sm_errs", errs, 0);
        check("sm_hs_low", hs_low, 256 * 7 * 2);
        check("sm_vs_low", vs_low, 256 * 12);
        check("sm_lt_cnt", lt_cnt, 256 * 7);
        check("sm_ft_cnt", ft_cnt, 256);
        check("sm_fc_255", fc_before_wrap, 8'hFF);
        check("sm_fc_wrap", s_fc, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
